mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one external memory port between the core's instruction bus and its data bus.
//  - Instruction bus is the prefetch path; data bus is the load/store path.
//  - Sits between the core and the memory/IO controller.
//  - Arbitrates between the two requesters and registers the winner's request.
//  - Steers the memory ack back to the winner only.
//  - Data has priority; a starvation limit guarantees forward progress for prefetch.
// PARAMETERS
//  STARVE_LIMIT  4  consecutive data grants allowed while an instr request waits (1..15)
// PORTS
//  clk               in   1   clock
//  reset             in   1   synchronous reset, active-low (0 = reset)
//  instr_m_addr      in   19  instr word address [19:1]
//  instr_m_access    in   1   instr request; held until instr_m_ack
//  instr_m_ack       out  1   instr transfer complete; data valid on instr_m_data_in
//  instr_m_data_in   out  16  read data to prefetch
//  data_m_addr       in   19  data word address [19:1]
//  data_m_data_out   in   16  write data from load/store
//  data_m_access     in   1   data request; held until data_m_ack
//  data_m_wr_en      in   1   1 = write
//  data_m_bytesel    in   2   byte lanes
//  d_io              in   1   data request targets IO space
//  lock              in   1   bus lock from core
//  data_m_ack        out  1   data transfer complete
//  data_m_data_in    out  16  read data to load/store
//  q_m_addr          out  19  memory address
//  q_m_data_out      out  16  memory write data
//  q_m_access        out  1   memory request
//  q_m_wr_en         out  1   memory write enable
//  q_m_bytesel       out  2   memory byte lanes
//  q_io              out  1   IO space select
//  q_m_ack           in   1   memory ack
//  q_m_data_in       in   16  memory read data
// BEHAVIOUR
//  Reset (reset==0 at posedge)
//  - state=IDLE, starve_cnt=0.
//  - All q_* outputs 0; both acks 0.
//  States: IDLE, SERVE_I, SERVE_D.
//  IDLE
//  - If any access is high, arbitrate, latch the winner's request into the q_* registers,
//    and go to SERVE_x. q_m_access is asserted the next cycle (1-cycle grant latency).
//  - The idle cycle between transactions is mandatory; q_m_access is never high for
//    two back-to-back transactions.
//  Arbitration order
//  - lock=1 and the previous grant was data: data wins if data_m_access.
//  - Else starve_cnt==STARVE_LIMIT and instr_m_access: instr wins.
//  - Else data_m_access: data wins.
//  - Else instr_m_access: instr wins.
//  Starvation counter
//  - starve_cnt increments on each data grant made while instr_m_access=1, saturating
//    at STARVE_LIMIT.
//  - starve_cnt clears on an instr grant, or in any IDLE cycle with instr_m_access=0.
//  Instr grant drives q_m_wr_en=0, q_m_bytesel=2'b11, q_io=0, q_m_data_out=0.
//  SERVE_x
//  - q_* registers are held stable; requester inputs are ignored.
//  - On q_m_ack, the winner's ack is driven combinationally that same cycle; the other
//    ack stays 0. State then returns to IDLE and q_m_access=0 from the next cycle.
//  Abandon
//  - If the winner drops access before q_m_ack, the downstream cycle still runs to ack.
//  - That ack is swallowed (not forwarded); then return to IDLE.
//  Read data
//  - q_m_data_in is broadcast unregistered to both *_data_in outputs; validity is
//    indicated only by the ack.
//  Requester contract
//  - Access is low, or carries a new request, in the cycle after its ack.
//  Other rules
//  - q_m_ack in IDLE is ignored.
//  - Reset mid-transaction returns to IDLE; a late ack after reset is ignored.
//  - Never more than one ack high per cycle.
// TESTING
//  1. Single instr read of addr 19'h00010; memory acks 3 cycles after q_m_access
//     -> q_m_access rises 1 cycle after request, bytesel=11, wr_en=0.
//     -> instr_m_ack pulses once with data 16'hBEEF; data_m_ack=0.
//  2. Both request in the same cycle -> data granted first.
//     -> Then IDLE for 1 cycle, then instr granted.
//  3. Continuous data requests plus a waiting instr request, STARVE_LIMIT=4
//     -> grant order D,D,D,D,I,D...
//  4. lock=1 with continuous data requests and starve_cnt at the limit
//     -> data keeps the grant until lock=0, then instr is next.
//  5. Data write 16'h1234 to 19'h7FFFF, bytesel=01, d_io=1
//     -> q_* fields match exactly, held stable until ack even if inputs change.
//  6. Winner drops access mid-transfer, or reset pulses mid-transfer
//     -> ack is not forwarded, FSM returns to IDLE, all outputs show reset values.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Purpose : shares one memory port between the instruction (prefetch) bus and the
//           data (load/store) bus; data has priority, a starvation limit lets prefetch in.
// Latency : request registered onto q_* one cycle after it is seen in IDLE; ack is
//           steered back combinationally in the q_m_ack cycle.
// Backpressure: a requester holds access until its ack; one transaction at a time,
//           with a mandatory idle cycle between transactions.
// Ports   : clk, reset (sync, active-low); instr_m_* / data_m_* / d_io / lock from the
//           core; q_* to the memory/IO controller; q_m_ack / q_m_data_in from memory.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] instr_m_addr,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  output logic [15:0] instr_m_data_in,
  input  logic [18:0] data_m_addr,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  input  logic        d_io,
  input  logic        lock,
  output logic        data_m_ack,
  output logic [15:0] data_m_data_in,
  output logic [18:0] q_m_addr,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  output logic        q_io,
  input  logic        q_m_ack,
  input  logic [15:0] q_m_data_in
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       last_data;   // previous grant went to the data bus (for lock)
  logic       abandoned;   // winner dropped access while its cycle was in flight
  logic       grant_any;
  logic       grant_data;
  logic       winner_access;
  logic       fwd_ack;

  // Arbitration: a locked data sequence keeps the bus, then a starved prefetch,
  // then plain data priority.
  always_comb begin
    grant_any = instr_m_access | data_m_access;
    if (lock && last_data && data_m_access)
      grant_data = 1'b1;
    else if ((starve_cnt == LIMIT) && instr_m_access)
      grant_data = 1'b0;
    else
      grant_data = data_m_access;
  end

  // The ack is only forwarded if the winner kept its request up for the whole
  // cycle, including the ack cycle itself; otherwise it is swallowed.
  assign winner_access = (state == SERVE_D) ? data_m_access : instr_m_access;
  assign fwd_ack       = q_m_ack && !abandoned && winner_access;
  assign instr_m_ack   = (state == SERVE_I) && fwd_ack;
  assign data_m_ack    = (state == SERVE_D) && fwd_ack;

  // Read data is broadcast; the ack alone qualifies it.
  assign instr_m_data_in = q_m_data_in;
  assign data_m_data_in  = q_m_data_in;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      starve_cnt   <= 4'd0;
      last_data    <= 1'b0;
      abandoned    <= 1'b0;
      q_m_addr     <= 19'd0;
      q_m_data_out <= 16'd0;
      q_m_access   <= 1'b0;
      q_m_wr_en    <= 1'b0;
      q_m_bytesel  <= 2'b00;
      q_io         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Counter only tracks a prefetch that is actually waiting.
          if (!instr_m_access)
            starve_cnt <= 4'd0;
          else if (grant_data) begin
            if (starve_cnt != LIMIT)
              starve_cnt <= starve_cnt + 4'd1;
          end else
            starve_cnt <= 4'd0;

          if (grant_any) begin
            abandoned  <= 1'b0;
            last_data  <= grant_data;
            q_m_access <= 1'b1;
            if (grant_data) begin
              state        <= SERVE_D;
              q_m_addr     <= data_m_addr;
              q_m_data_out <= data_m_data_out;
              q_m_wr_en    <= data_m_wr_en;
              q_m_bytesel  <= data_m_bytesel;
              q_io         <= d_io;
            end else begin
              state        <= SERVE_I;
              q_m_addr     <= instr_m_addr;
              q_m_data_out <= 16'd0;
              q_m_wr_en    <= 1'b0;
              q_m_bytesel  <= 2'b11;
              q_io         <= 1'b0;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (q_m_ack) begin
            // Clearing the whole request guarantees the idle gap before the next grant.
            state        <= IDLE;
            abandoned    <= 1'b0;
            q_m_addr     <= 19'd0;
            q_m_data_out <= 16'd0;
            q_m_access   <= 1'b0;
            q_m_wr_en    <= 1'b0;
            q_m_bytesel  <= 2'b00;
            q_io         <= 1'b0;
          end else if (!winner_access) begin
            abandoned <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose : randomized + directed check of mem_bus_arbiter against a transaction model.
// Latency : model predicts grant one cycle after request, ack in the memory ack cycle.
// Backpressure: bench requesters hold access until ack; memory acks after a set delay.
module tb_mem_bus_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] instr_m_addr, data_m_addr, q_m_addr;
  logic        instr_m_access, instr_m_ack;
  logic [15:0] instr_m_data_in, data_m_data_out, data_m_data_in;
  logic        data_m_access, data_m_wr_en, d_io, lock, data_m_ack;
  logic [1:0]  data_m_bytesel, q_m_bytesel;
  logic [15:0] q_m_data_out, q_m_data_in;
  logic        q_m_access, q_m_wr_en, q_io, q_m_ack;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .instr_m_addr(instr_m_addr), .instr_m_access(instr_m_access),
    .instr_m_ack(instr_m_ack), .instr_m_data_in(instr_m_data_in),
    .data_m_addr(data_m_addr), .data_m_data_out(data_m_data_out),
    .data_m_access(data_m_access), .data_m_wr_en(data_m_wr_en),
    .data_m_bytesel(data_m_bytesel), .d_io(d_io), .lock(lock),
    .data_m_ack(data_m_ack), .data_m_data_in(data_m_data_in),
    .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_access(q_m_access),
    .q_m_wr_en(q_m_wr_en), .q_m_bytesel(q_m_bytesel), .q_io(q_io),
    .q_m_ack(q_m_ack), .q_m_data_in(q_m_data_in)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Transaction model: one outstanding memory cycle, its latched request and winner.
  bit          busy, win_d, aband, last_d;
  int          starve, cnt;
  logic [18:0] e_addr;
  logic [15:0] e_dout;
  logic        e_wr, e_io;
  logic [1:0]  e_bs;
  bit          grant_log[$];   // 1 = data grant, 0 = instr grant

  // Bench requesters / memory knobs
  bit i_pend, d_pend, i_acked, d_acked, late_ack;
  int p_i, p_d, p_ab, lat, lock_grants, n_iack, n_dack;
  bit lock_rand, fixed_d, scramble, beef;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    e_addr = '0; e_dout = '0; e_wr = 1'b0; e_io = 1'b0; e_bs = 2'b00;
  endtask

  task automatic new_i();
    instr_m_addr = 19'($urandom);
  endtask

  task automatic new_d();
    if (fixed_d) begin
      data_m_addr = 19'h7FFFF; data_m_data_out = 16'h1234;
      data_m_wr_en = 1'b1; data_m_bytesel = 2'b01; d_io = 1'b1;
    end else begin
      data_m_addr = 19'($urandom); data_m_data_out = 16'($urandom);
      data_m_wr_en = 1'($urandom); data_m_bytesel = 2'($urandom); d_io = 1'($urandom);
    end
  endtask

  // One clock: drive at negedge, compare outputs, then advance the model
  // to what the coming posedge must do.
  task automatic cycle(input bit rst);
    bit ei, ed, g, granted;
    @(negedge clk);
    // instruction requester
    if (i_acked) begin
      i_pend = ($urandom_range(0, 99) < p_i);
      if (i_pend) new_i();
    end else if (!i_pend) begin
      if ($urandom_range(0, 99) < p_i) begin i_pend = 1; new_i(); end
      else new_i();
    end else if (busy && !win_d && $urandom_range(0, 99) < p_ab)
      i_pend = 0;
    instr_m_access = i_pend;
    // data requester
    if (d_acked) begin
      d_pend = ($urandom_range(0, 99) < p_d);
      if (d_pend) new_d();
    end else if (!d_pend) begin
      if ($urandom_range(0, 99) < p_d) begin d_pend = 1; new_d(); end
    end else if (busy && win_d && $urandom_range(0, 99) < p_ab)
      d_pend = 0;
    else if (busy && win_d && scramble) begin
      fixed_d = 0; new_d(); fixed_d = 1;
    end
    data_m_access = d_pend;
    lock  = lock_rand ? 1'($urandom) : (grant_log.size() < lock_grants);
    reset = !rst;
    // memory side
    if (rst) q_m_ack = 1'b0;
    else if (busy) q_m_ack = (cnt == 0);
    else q_m_ack = late_ack ? 1'b1 : ($urandom_range(0, 3) == 0);
    late_ack = 0;
    q_m_data_in = beef ? 16'hBEEF : 16'($urandom);
    #1;
    ei = busy && !win_d && q_m_ack && !aband && instr_m_access;
    ed = busy &&  win_d && q_m_ack && !aband && data_m_access;
    chk("q_m_access", 32'(q_m_access), 32'(busy));
    chk("q_m_addr", 32'(q_m_addr), 32'(e_addr));
    chk("q_m_data_out", 32'(q_m_data_out), 32'(e_dout));
    chk("q_m_wr_en", 32'(q_m_wr_en), 32'(e_wr));
    chk("q_m_bytesel", 32'(q_m_bytesel), 32'(e_bs));
    chk("q_io", 32'(q_io), 32'(e_io));
    chk("instr_m_ack", 32'(instr_m_ack), 32'(ei));
    chk("data_m_ack", 32'(data_m_ack), 32'(ed));
    chk("instr_m_data_in", 32'(instr_m_data_in), 32'(q_m_data_in));
    chk("data_m_data_in", 32'(data_m_data_in), 32'(q_m_data_in));
    if (ei) n_iack++;
    if (ed) n_dack++;
    i_acked = ei;
    d_acked = ed;
    if (rst) begin
      busy = 0; starve = 0; last_d = 0; aband = 0; clear_exp();
      i_pend = 0; d_pend = 0; i_acked = 0; d_acked = 0; late_ack = 1;
    end else if (!busy) begin
      granted = instr_m_access || data_m_access;
      if (lock && last_d && data_m_access) g = 1;
      else if (starve == LIMIT && instr_m_access) g = 0;
      else g = data_m_access;
      if (!instr_m_access || (granted && !g)) starve = 0;
      else if (granted && g && starve < LIMIT) starve++;
      if (granted) begin
        busy = 1; win_d = g; aband = 0; last_d = g;
        cnt = (lat < 0) ? $urandom_range(0, 3) : lat;
        grant_log.push_back(g);
        if (g) begin
          e_addr = data_m_addr; e_dout = data_m_data_out; e_wr = data_m_wr_en;
          e_bs = data_m_bytesel; e_io = d_io;
        end else begin
          e_addr = instr_m_addr; e_dout = '0; e_wr = 0; e_bs = 2'b11; e_io = 0;
        end
      end
    end else if (q_m_ack) begin
      busy = 0; clear_exp();
    end else begin
      if (!(win_d ? data_m_access : instr_m_access)) aband = 1;
      cnt--;
    end
  endtask

  task automatic quiet();
    p_i = 0; p_d = 0; p_ab = 0; lock_rand = 0; lock_grants = 0;
    fixed_d = 0; scramble = 0; beef = 0; lat = -1;
  endtask

  initial begin
    quiet();
    busy = 0; win_d = 0; aband = 0; last_d = 0; starve = 0; cnt = 0;
    i_pend = 0; d_pend = 0; i_acked = 0; d_acked = 0; late_ack = 0;
    clear_exp();
    reset = 1'b0; instr_m_addr = '0; instr_m_access = 0; data_m_addr = '0;
    data_m_data_out = '0; data_m_access = 0; data_m_wr_en = 0; data_m_bytesel = '0;
    d_io = 0; lock = 0; q_m_ack = 0; q_m_data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q_m_access", 32'(q_m_access), 32'd0);
    chk("rst_q_m_addr", 32'(q_m_addr), 32'd0);
    chk("rst_q_m_bytesel", 32'(q_m_bytesel), 32'd0);
    chk("rst_acks", 32'({instr_m_ack, data_m_ack}), 32'd0);

    // 1: single instr read of 0x00010, memory acks 3 cycles after q_m_access
    beef = 1; lat = 3; n_iack = 0; n_dack = 0;
    i_pend = 1; instr_m_addr = 19'h00010;
    repeat (8) cycle(0);
    chk("t1_iack_count", 32'(n_iack), 32'd1);
    chk("t1_dack_count", 32'(n_dack), 32'd0);
    beef = 0; lat = -1;

    // 2: both request together -> D then I
    grant_log.delete();
    i_pend = 1; new_i(); d_pend = 1; new_d();
    repeat (14) cycle(0);
    chk("t2_grants", 32'(grant_log.size()), 32'd2);
    chk("t2_first_d", 32'(grant_log[0]), 32'd1);
    chk("t2_second_i", 32'(grant_log[1]), 32'd0);

    // 3: continuous data with a waiting prefetch -> D,D,D,D,I,D
    cycle(1);
    grant_log.delete(); p_i = 100; p_d = 100;
    for (int k = 0; k < 300 && grant_log.size() < 6; k++) cycle(0);
    chk("t3_grants", 32'(grant_log.size() >= 6), 32'd1);
    for (int k = 0; k < 6; k++)
      chk($sformatf("t3_grant%0d", k), 32'(grant_log[k]), (k == 4) ? 32'd0 : 32'd1);
    p_i = 0; p_d = 0;
    repeat (20) cycle(0);

    // 4: lock holds data past the starvation limit; instr next once lock drops
    cycle(1);
    grant_log.delete(); p_i = 100; p_d = 100; lock_grants = 8;
    for (int k = 0; k < 300 && grant_log.size() < 9; k++) cycle(0);
    chk("t4_grants", 32'(grant_log.size() >= 9), 32'd1);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t4_lock%0d", k), 32'(grant_log[k]), 32'd1);
    chk("t4_after_lock", 32'(grant_log[8]), 32'd0);
    quiet();
    repeat (20) cycle(0);

    // 5: data write to the top address, inputs scrambled while in flight
    cycle(1);
    fixed_d = 1; scramble = 1; lat = 4; n_dack = 0;
    d_pend = 1; new_d();
    cycle(0);
    cycle(0);
    chk("t5_addr", 32'(q_m_addr), 32'h7FFFF);
    chk("t5_dout", 32'(q_m_data_out), 32'h1234);
    chk("t5_bs", 32'(q_m_bytesel), 32'd1);
    chk("t5_io_wr", 32'({q_io, q_m_wr_en}), 32'd3);
    repeat (8) cycle(0);
    chk("t5_dack_count", 32'(n_dack), 32'd1);
    quiet();

    // 6: random traffic with abandons, lock and mid-transfer reset pulses
    p_i = 35; p_d = 35; p_ab = 8; lock_rand = 1;
    for (int k = 0; k < 2000; k++) cycle(busy && ($urandom_range(0, 49) == 0));
    quiet();
    repeat (20) cycle(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
